// File: rtl/pcm_tdm_pkg.sv
// Shared constants and types for the PCM TDM transmitter.
// Build option: define PCM_TDM_EVEN_BIT_INV_EN to XOR every transmitted
// byte (data or idle) with EBI_MASK at slot load.
package pcm_tdm_pkg;

    localparam logic [7:0] ALAW_IDLE = 8'hD5;
    localparam logic [7:0] ULAW_IDLE = 8'hFF;
    localparam logic [7:0] EBI_MASK  = 8'h55;

    typedef enum logic {IDLE, RUN} state_e;

    // Line coding applied to a byte as it enters the shift register
    function automatic logic [7:0] line_byte(input logic [7:0] b);
`ifdef PCM_TDM_EVEN_BIT_INV_EN
        return b ^ EBI_MASK;
`else
        return b;
`endif
    endfunction

endpackage

// File: rtl/pcm_sync_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the oldest entry so a
// pop and its consumer's load happen in the same cycle.
module pcm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is fine when a pop frees the slot that cycle
    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CW'(1);
        else if (do_pop && !do_push)
            count_d = count_q - CW'(1);
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/pcm_tdm_tx.sv
// PCM TDM transmitter: buffers PCM codes and shifts them out MSB-first,
// one 8-bit slot per channel, with a frame-sync on slot 0 bit 7.
// Build option: PCM_TDM_EVEN_BIT_INV_EN (alternate-bit inversion at load).
module pcm_tdm_tx
    import pcm_tdm_pkg::*;
#(
    parameter int NUM_CH     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       law,
    input  logic       en,
    input  logic       bclk_en,
    input  logic [7:0] pcm_in,
    input  logic       pcm_valid,
    output logic       pcm_ready,
    output logic       sdo,
    output logic       fs,
    output logic       underrun,
    input  logic       clr_underrun
);

    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CH - 1);

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          sdo_q, sdo_d;
    logic          fs_q, fs_d;
    logic          underrun_q, underrun_d;

    logic          fifo_full, fifo_empty, fifo_pop, load, set_underrun;
    logic [7:0]    fifo_dout, tx_byte;

    assign pcm_ready = !fifo_full;
    assign sdo       = sdo_q;
    assign fs        = fs_q;
    assign underrun  = underrun_q;

    pcm_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pcm_valid && !fifo_full),
        .pop   (fifo_pop),
        .din   (pcm_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Framer: advance on each bit strobe, load a new slot at slot boundaries
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        slot_cnt_d   = slot_cnt_q;
        shift_d      = shift_q;
        sdo_d        = sdo_q;
        fs_d         = fs_q;
        load         = 1'b0;
        fifo_pop     = 1'b0;
        set_underrun = 1'b0;
        tx_byte      = '0;
        if (bclk_en) begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d    = RUN;
                        slot_cnt_d = '0;
                        load       = 1'b1;
                    end else begin
                        sdo_d = 1'b0;
                        fs_d  = 1'b0;
                    end
                end
                RUN: begin
                    if (bit_cnt_q != 3'd0) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        sdo_d     = shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        fs_d      = 1'b0;
                    end else if (slot_cnt_q == LAST_SLOT) begin
                        slot_cnt_d = '0;
                        if (en) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            sdo_d   = 1'b0;
                            fs_d    = 1'b0;
                        end
                    end else begin
                        slot_cnt_d = slot_cnt_q + SW'(1);
                        load       = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // A byte pushed this same cycle is not yet visible: empty wins
        if (load) begin
            fifo_pop     = !fifo_empty;
            set_underrun = fifo_empty;
            tx_byte      = line_byte(fifo_empty ? (law ? ALAW_IDLE : ULAW_IDLE)
                                                : fifo_dout);
            sdo_d        = tx_byte[7];
            shift_d      = {tx_byte[6:0], 1'b0};
            bit_cnt_d    = 3'd7;
            fs_d         = (slot_cnt_d == '0);
        end
        underrun_d = (underrun_q && !clr_underrun) || set_underrun;
    end

    // Framer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            slot_cnt_q <= '0;
            shift_q    <= '0;
            sdo_q      <= 1'b0;
            fs_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            shift_q    <= shift_d;
            sdo_q      <= sdo_d;
            fs_q       <= fs_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_pcm_tdm_tx.sv
// Self-checking bench for pcm_tdm_tx (NUM_CH=4, FIFO_DEPTH=8).
module tb_pcm_tdm_tx;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int FBITS  = NUM_CH * 8;
`ifdef PCM_TDM_EVEN_BIT_INV_EN
    localparam logic [7:0] MASK = 8'h55;
`else
    localparam logic [7:0] MASK = 8'h00;
`endif

    logic clk = 1'b0;
    logic rst_n, law, en, bclk_en, pcm_valid, clr_underrun;
    logic [7:0] pcm_in;
    logic pcm_ready, sdo, fs, underrun;

    always #5 clk = ~clk;

    pcm_tdm_tx #(.NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .law          (law),
        .en           (en),
        .bclk_en      (bclk_en),
        .pcm_in       (pcm_in),
        .pcm_valid    (pcm_valid),
        .pcm_ready    (pcm_ready),
        .sdo          (sdo),
        .fs           (fs),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: frame position as a plain bit index, bytes in a queue
    logic [7:0] q[$];
    int         pos = -1;          // -1 idle, else 0..FBITS-1 within frame
    logic [7:0] cur = '0;          // line byte of current slot
    logic       exp_sdo = 0, exp_fs = 0, exp_und = 0;
    logic [31:0] acc;
    int          fs_hits;

    function automatic logic [7:0] idle_code(input logic l);
        return (l ? 8'hD5 : 8'hFF) ^ MASK;
    endfunction

    task automatic model_reset();
        q.delete();
        pos = -1; cur = '0;
        exp_sdo = 0; exp_fs = 0; exp_und = 0;
    endtask

    // One clk cycle: drive, clock, update model, compare all outputs
    task automatic step(input logic b, input logic v, input logic [7:0] d, input logic c);
        logic rdy_m, set, en_s, law_s;
        bclk_en = b; pcm_valid = v; pcm_in = d; clr_underrun = c;
        rdy_m = (q.size() < DEPTH);
        en_s = en; law_s = law;
        set = 1'b0;
        @(posedge clk);
        if (b) begin
            if (pos < 0) begin
                if (en_s) pos = 0;
            end else begin
                pos++;
                if (pos == FBITS) pos = en_s ? 0 : -1;
            end
            if (pos >= 0 && pos % 8 == 0) begin
                if (q.size() > 0) cur = q.pop_front() ^ MASK;
                else begin cur = idle_code(law_s); set = 1'b1; end
            end
            if (pos >= 0) begin
                exp_sdo = cur[7 - pos % 8];
                exp_fs  = (pos == 0);
            end else begin
                exp_sdo = 1'b0;
                exp_fs  = 1'b0;
            end
        end
        if (v && rdy_m) q.push_back(d);
        exp_und = (exp_und && !c) || set;
        #1;
        chk("sdo", 32'(sdo), 32'(exp_sdo));
        chk("fs", 32'(fs), 32'(exp_fs));
        chk("underrun", 32'(underrun), 32'(exp_und));
        chk("pcm_ready", 32'(pcm_ready), 32'(q.size() < DEPTH));
        acc = {acc[30:0], sdo};
        if (fs) fs_hits++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; law = 1'b1; en = 1'b0; bclk_en = 1'b0;
        pcm_in = '0; pcm_valid = 1'b0; clr_underrun = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_sdo", 32'(sdo), 32'd0);
        chk("rst_fs", 32'(fs), 32'd0);
        chk("rst_ready", 32'(pcm_ready), 32'd1);
        chk("rst_underrun", 32'(underrun), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Preloaded frame
        en = 1'b1; law = 1'b1;
        step(0, 1, 8'hA5, 0); step(0, 1, 8'h3C, 0);
        step(0, 1, 8'h00, 0); step(0, 1, 8'hFF, 0);
        acc = '0; fs_hits = 0;
        for (int i = 0; i < 32; i++) step(1, 0, 8'h00, 0);
        chk("frame_data", acc, 32'hA53C00FF ^ {4{MASK}});
        chk("frame_fs_once", 32'(fs_hits), 32'd1);
        chk("frame_no_underrun", 32'(underrun), 32'd0);

        // Idle fill, A-law then u-law
        for (int i = 0; i < 32; i++) step(1, 0, 8'h00, 0);
        chk("idle_alaw", acc, {4{8'hD5 ^ MASK}});
        chk("idle_underrun", 32'(underrun), 32'd1);
        law = 1'b0;
        for (int i = 0; i < 32; i++) step(1, 0, 8'h00, 0);
        chk("idle_ulaw", acc, {4{8'hFF ^ MASK}});
        step(0, 0, 8'h00, 1);
        chk("clr_underrun", 32'(underrun), 32'd0);
        step(1, 0, 8'h00, 1);           // frame start on empty FIFO: set wins
        chk("set_beats_clr", 32'(underrun), 32'd1);

        // Fill FIFO with no strobes; ninth byte held off until a slot load
        for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h10 + i), 0);
        chk("full_after_8", 32'(pcm_ready), 32'd0);
        step(0, 1, 8'h99, 0);
        while (pos % 8 != 7) step(1, 1, 8'h99, 0);
        step(1, 1, 8'h99, 0);           // slot load pops one byte
        chk("ready_after_pop", 32'(pcm_ready), 32'd1);
        step(0, 1, 8'h99, 0);
        chk("ninth_accepted", 32'(pcm_ready), 32'd0);

        // en dropped mid-frame: frame completes, then line idles
        while (pos != 4) step(1, 0, 8'h00, 0);
        en = 1'b0;
        for (int i = 0; i < 27; i++) step(1, 0, 8'h00, 0);
        chk("frame_completes", 32'(pos), 32'(FBITS - 1));
        fs_hits = 0; acc = '0;
        for (int i = 0; i < 32; i++) step(1, 0, 8'h00, 0);
        chk("off_sdo_zero", acc, 32'd0);
        chk("off_fs_zero", 32'(fs_hits), 32'd0);
        en = 1'b1;
        step(1, 0, 8'h00, 0);
        chk("restart_fs", 32'(fs), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 49) == 0) law = ~law;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                 8'($urandom), 1'($urandom_range(0, 19) == 0));
        end

        // Reset at slot 2 bit 4
        en = 1'b1;
        for (int i = 0; i < 400 && pos != 19; i++)
            step(1, 1'($urandom_range(0, 1)), 8'($urandom), 0);
        chk("reached_slot2_bit4", 32'(pos), 32'd19);
        step(0, 1, 8'h5A, 0);           // leave a byte in the FIFO
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sdo", 32'(sdo), 32'd0);
        chk("mid_rst_fs", 32'(fs), 32'd0);
        chk("mid_rst_ready", 32'(pcm_ready), 32'd1);
        chk("mid_rst_underrun", 32'(underrun), 32'd0);
        model_reset();
        bclk_en = 1'b0; pcm_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        chk("post_rst_fs", 32'(fs), 32'd1);
        chk("post_rst_fifo_empty", 32'(underrun), 32'd1);
        for (int i = 0; i < 40; i++) step(1, 1'($urandom_range(0, 1)), 8'($urandom), 0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pcm_tdm_tx.md
Name: pcm_tdm_tx

Overview:
- Downstream neighbour of the G.711 compressor. Accepts the 8-bit PCM codes it produces, one per channel in channel order, through a valid/ready handshake.
- Buffers the codes in a small FIFO and shifts them out MSB-first on a serial TDM line with a frame-sync pulse, one 8-bit slot per channel.
- Fills any starved slot with the law-dependent idle code.

Parameters:
- NUM_CH, 32, TDM slots per frame (2..64)
- FIFO_DEPTH, 8, PCM byte buffer depth (power of 2, >=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- law  in  1  1 = A-law, 0 = u-law; selects idle code; sampled at each slot load
- en  in  1  transmit enable; sampled only at frame start
- bclk_en  in  1  one-cycle strobe, one serial bit per strobe
- pcm_in  in  8  PCM code from compressor
- pcm_valid  in  1  pcm_in valid
- pcm_ready  out  1  FIFO not full
- sdo  out  1  serial data, MSB first
- fs  out  1  frame sync, high for the bclk_en interval carrying slot 0 bit 7
- underrun  out  1  sticky; set when a slot is idle-filled during an active frame
- clr_underrun  in  1  synchronous clear of underrun

Behaviour:
- Reset values: sdo=0, fs=0, pcm_ready=1, underrun=0. Reset also empties the FIFO, sets bit_cnt=0, slot_cnt=0, state=IDLE and clears the shift register.
- Reset mid-frame aborts the frame immediately. The first frame after reset starts only at a new frame start.
- Write handshake: a byte is accepted when pcm_valid && pcm_ready on a clk edge.
- pcm_ready is combinational from FIFO count (!full).
- Simultaneous push and pop while full is allowed: count stays unchanged, no drop.
- State machine, IDLE / RUN:
  - IDLE: on bclk_en, if en=1, go to RUN and load slot 0 in the same cycle. Otherwise sdo=0, fs=0, no pop.
  - RUN: every bclk_en advances bit_cnt 7 down to 0.
  - At bit_cnt wrap, slot_cnt increments.
  - At slot_cnt = NUM_CH-1 and bit 0 (end of frame), re-sample en: en=1 loads slot 0 of the next frame on the next strobe with no gap; en=0 returns to IDLE.
- Slot load, on the strobe beginning a slot:
  - FIFO non-empty: pop one byte into the shift register, sdo <= byte[7].
  - FIFO empty: load idle code (A-law 8'hD5, u-law 8'hFF), sdo <= idle[7], set underrun.
  - Remaining bits: sdo <= next bit on each following strobe.
  - sdo and fs are registered and change only on bclk_en cycles.
- fs=1 only for the slot 0 / bit 7 interval; it falls on the next strobe.
- A byte written in the same cycle as a slot load into an empty FIFO is NOT used for that slot; the idle code is sent.
- Underrun flag: clr_underrun clears it. If a set and a clear coincide, the set wins.
- bclk_en may be high on consecutive cycles; the minimum spacing is 1 clk.
- Width rules: slot_cnt is clog2(NUM_CH) bits; FIFO count is clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro PCM_TDM_EVEN_BIT_INV_EN.
- Defined: every transmitted byte, data or idle, is XORed with 8'h55 at load. This is alternate-bit inversion for line formats that expect it applied at the framer rather than in the coder.
- Undefined: bytes are transmitted unchanged. No extra ports either way.

Decomposition:
- Shared package pcm_tdm_pkg:
  - ALAW_IDLE = 8'hD5
  - ULAW_IDLE = 8'hFF
  - EBI_MASK = 8'h55
  - state enum {IDLE, RUN}
- One sub-module: pcm_sync_fifo.
  - Synchronous FIFO, parameterised width and depth.
  - Ports: push, pop, din, dout, full, empty.
  - dout is a show-ahead (first-word fall-through) register, so the pop and the load occur in the same cycle.
  - Framer counters and the state machine stay in pcm_tdm_tx.

Test Plan:
- NUM_CH=4, en=1, law=1: preload 4 bytes 8'hA5, 8'h3C, 8'h00, 8'hFF, then strobe 32 times.
  - sdo = 10100101 00111100 00000000 11111111.
  - fs high only on strobe 1; underrun=0.
- Empty FIFO, en=1:
  - law=1 gives every slot 11010101 and sets underrun.
  - law=0 gives 11111111.
  - clr_underrun=1 clears the flag; a clear coinciding with a new idle fill leaves underrun=1.
- Write 9 bytes with no strobes, FIFO_DEPTH=8:
  - pcm_ready drops after the 8th accept; 9th held off.
  - After the first slot load, pcm_ready=1 again and the 9th byte is accepted.
- en dropped mid-frame 2:
  - frame 2 completes all NUM_CH*8 bits.
  - Then sdo=0, fs stays 0, no FIFO pops until en=1 at a frame start.
- rst_n asserted at slot 2 bit 4:
  - outputs go to reset values immediately, FIFO empty.
  - After release, fs appears on the first strobe with en=1.
- PCM_TDM_EVEN_BIT_INV_EN defined, byte 8'h00: transmitted as 01010101; idle A-law becomes 8'h80.
